// File: rtl/structure2_cnn_pkg.sv
// Shared widths, FSM encoding and saturation helper for the structure2 CNN blocks.
package structure2_cnn_pkg;

    localparam int DATA_W = 18;
    localparam int ADDR_W = 14;
    localparam int IDX_W  = 4;
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = 40;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_OUT   = 3'd3,
        ST_FIN   = 3'd4
    } fc2_state_e;

    localparam logic signed [ACC_W:0] SAT_MAX = 41'sd131071;
    localparam logic signed [ACC_W:0] SAT_MIN = -41'sd131072;

    function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [ACC_W:0] v);
        if (v > SAT_MAX)      sat_data = DATA_W'(SAT_MAX);
        else if (v < SAT_MIN) sat_data = DATA_W'(SAT_MIN);
        else                  sat_data = v[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/structure2_fc2_mac.sv
// fc2 multiply-accumulate with rescale, bias add and saturation.
// Optional ReLU clamp is selected by STRUCTURE2_FC2_RELU_EN.
module structure2_fc2_mac
    import structure2_cnn_pkg::*;
#(
    parameter int FRAC = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     rd_en,
    input  logic signed [DATA_W-1:0] act,
    input  logic signed [DATA_W-1:0] wgt,
    input  logic signed [DATA_W-1:0] bias,
    output logic signed [DATA_W-1:0] res
);

    logic                     vld_q, vld_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [ACC_W:0]    biased;
    logic signed [DATA_W-1:0] sat;

    assign prod = act * wgt;

    // Buffer/ROM data lands one cycle after the read, so the add trails fc2en by one.
    always_comb begin
        vld_d = rd_en;
        acc_d = acc_q;
        if (clr)
            acc_d = '0;
        else if (vld_q)
            acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            acc_q <= '0;
        end else begin
            vld_q <= vld_d;
            acc_q <= acc_d;
        end
    end

    assign shifted = acc_q >>> FRAC;
    assign biased  = {shifted[ACC_W-1], shifted} + {{(ACC_W+1-DATA_W){bias[DATA_W-1]}}, bias};
    assign sat     = sat_data(biased);

`ifdef STRUCTURE2_FC2_RELU_EN
    assign res = sat[DATA_W-1] ? '0 : sat;
`else
    assign res = sat;
`endif

endmodule

// File: rtl/structure2_fc2_layer.sv
// fc2 layer: sequences buffer/weight/bias reads per neuron and emits one result each.
// Build option STRUCTURE2_FC2_RELU_EN enables ReLU on the results.
module structure2_fc2_layer
    import structure2_cnn_pkg::*;
#(
    parameter int IN_LEN  = 128,
    parameter int OUT_LEN = 10,
    parameter int FRAC    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     fc2en,
    output logic [ADDR_W-1:0]        fc2dataaddr,
    input  logic signed [DATA_W-1:0] fc2dataout,
    output logic [ADDR_W-1:0]        waddr,
    input  logic signed [DATA_W-1:0] wdata,
    output logic [IDX_W-1:0]         baddr,
    input  logic signed [DATA_W-1:0] bdata,
    output logic                     out_valid,
    output logic [IDX_W-1:0]         out_idx,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     busy,
    output logic                     done
);

    localparam logic [ADDR_W-1:0] LAST_I = ADDR_W'(IN_LEN - 1);
    localparam logic [IDX_W-1:0]  LAST_O = IDX_W'(OUT_LEN - 1);

    fc2_state_e               state_q;
    logic [ADDR_W-1:0]        i_q;
    logic [ADDR_W-1:0]        waddr_q;
    logic [IDX_W-1:0]         o_q;
    logic                     fc2en_q;
    logic                     out_valid_q;
    logic [IDX_W-1:0]         out_idx_q;
    logic signed [DATA_W-1:0] out_data_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     acc_clr;
    logic signed [DATA_W-1:0] mac_res;

    // Accumulator is cleared on the same edge that enters READ.
    assign acc_clr = ((state_q == ST_IDLE) && start) ||
                     ((state_q == ST_OUT) && (o_q != LAST_O));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            i_q         <= '0;
            waddr_q     <= '0;
            o_q         <= '0;
            fc2en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                ST_IDLE: if (start) begin
                    state_q <= ST_READ;
                    busy_q  <= 1'b1;
                    fc2en_q <= 1'b1;
                    i_q     <= '0;
                    o_q     <= '0;
                    waddr_q <= '0;
                end
                ST_READ: begin
                    if (i_q == LAST_I) begin
                        state_q <= ST_DRAIN;
                        fc2en_q <= 1'b0;
                    end else begin
                        i_q     <= i_q + 1'b1;
                        waddr_q <= waddr_q + 1'b1;
                    end
                end
                ST_DRAIN: state_q <= ST_OUT;
                ST_OUT: begin
                    out_valid_q <= 1'b1;
                    out_idx_q   <= o_q;
                    out_data_q  <= mac_res;
                    if (o_q == LAST_O) begin
                        state_q <= ST_FIN;
                    end else begin
                        // Weight rows are contiguous, so the next neuron starts at waddr+1.
                        state_q <= ST_READ;
                        o_q     <= o_q + 1'b1;
                        i_q     <= '0;
                        waddr_q <= waddr_q + 1'b1;
                        fc2en_q <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    structure2_fc2_mac #(.FRAC(FRAC)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .rd_en (fc2en_q),
        .act   (fc2dataout),
        .wgt   (wdata),
        .bias  (bdata),
        .res   (mac_res)
    );

    assign fc2en       = fc2en_q;
    assign fc2dataaddr = i_q;
    assign waddr       = waddr_q;
    assign baddr       = o_q;
    assign out_valid   = out_valid_q;
    assign out_idx     = out_idx_q;
    assign out_data    = out_data_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_structure2_fc2_layer.sv
// Scoreboard bench for structure2_fc2_layer with IN_LEN=4, OUT_LEN=2, FRAC=8.
module tb_structure2_fc2_layer;

    localparam int IN_LEN  = 4;
    localparam int OUT_LEN = 2;
    localparam int FRAC    = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               fc2en;
    logic [13:0]        fc2dataaddr;
    logic signed [17:0] fc2dataout = '0;
    logic [13:0]        waddr;
    logic signed [17:0] wdata = '0;
    logic [3:0]         baddr;
    logic signed [17:0] bdata = '0;
    logic               out_valid;
    logic [3:0]         out_idx;
    logic signed [17:0] out_data;
    logic               busy;
    logic               done;

    structure2_fc2_layer #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .FRAC(FRAC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .fc2en(fc2en), .fc2dataaddr(fc2dataaddr), .fc2dataout(fc2dataout),
        .waddr(waddr), .wdata(wdata), .baddr(baddr), .bdata(bdata),
        .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int act_m [IN_LEN];
    int wgt_m [IN_LEN*OUT_LEN];
    int bia_m [OUT_LEN];

    // Synchronous buffer and ROM models: data one cycle after address.
    always @(posedge clk) begin
        if (fc2en) fc2dataout <= 18'(act_m[fc2dataaddr[1:0]]);
        wdata <= 18'(wgt_m[waddr[2:0]]);
        bdata <= 18'(bia_m[baddr[0]]);
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    int    exp_idx[$];
    int    exp_dat[$];
    int    exp_ra[$];
    int    exp_wa[$];
    int    exp_ba[$];

    function automatic int model(input int o);
        longint acc = 0;
        for (int i = 0; i < IN_LEN; i++)
            acc += longint'(act_m[i]) * longint'(wgt_m[o*IN_LEN+i]);
        acc = acc >>> FRAC;
        acc += bia_m[o];
        if (acc > 131071)  acc = 131071;
        if (acc < -131072) acc = -131072;
`ifdef STRUCTURE2_FC2_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return int'(acc);
    endfunction

    always @(negedge clk) begin
        if (rst_n && fc2en) begin
            if (exp_ra.size() == 0) chk("fc2en_spurious", 1, 0);
            else begin
                chk("fc2dataaddr", fc2dataaddr, exp_ra.pop_front());
                chk("waddr", waddr, exp_wa.pop_front());
                chk("baddr", baddr, exp_ba.pop_front());
            end
        end
        if (rst_n && out_valid) begin
            if (exp_idx.size() == 0) chk("out_spurious", 1, 0);
            else begin
                chk("out_idx", out_idx, exp_idx.pop_front());
                chk("out_data", out_data, exp_dat.pop_front());
            end
        end
    end

    task automatic push_job();
        for (int o = 0; o < OUT_LEN; o++) begin
            for (int i = 0; i < IN_LEN; i++) begin
                exp_ra.push_back(i);
                exp_wa.push_back(o*IN_LEN + i);
                exp_ba.push_back(o);
            end
            exp_idx.push_back(o);
            exp_dat.push_back(model(o));
        end
    endtask

    task automatic load(input int a, input int w, input int b);
        foreach (act_m[i]) act_m[i] = a;
        foreach (wgt_m[i]) wgt_m[i] = w;
        foreach (bia_m[i]) bia_m[i] = b;
    endtask

    // Pulse start, optionally re-pulse it while busy, and time the done pulse.
    task automatic run_job(input int repulse_at);
        int k;
        push_job();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("busy_after_start", busy, 1);
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
            start = (k == repulse_at);
        end
        start = 1'b0;
        chk("done_latency", k, 13);
        chk("busy_at_done", busy, 0);
        chk("outs_left", exp_idx.size(), 0);
        chk("reads_left", exp_ra.size(), 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("fc2en_idle", fc2en, 0);
    endtask

    initial begin
        #1;
        chk("rst_fc2en", fc2en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        load(256, 256, 0);
        run_job(0);
        load(256, -256, 0);
        run_job(0);
        load(131071, 131071, 0);
        run_job(0);
        load(131071, -131072, 0);
        run_job(0);

        // Mixed signs and biases, with start re-pulsed mid-run.
        for (int t = 0; t < 3; t++) begin
            foreach (act_m[i]) act_m[i] = $urandom_range(4000) - 2000;
            foreach (wgt_m[i]) wgt_m[i] = $urandom_range(4000) - 2000;
            foreach (bia_m[i]) bia_m[i] = $urandom_range(2000) - 1000;
            run_job(3 + 3*t);
        end

        // Reset during READ clears everything at once.
        load(256, 256, 0);
        push_job();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_fc2en", fc2en, 0);
        chk("midrst_fc2dataaddr", fc2dataaddr, 0);
        chk("midrst_waddr", waddr, 0);
        chk("midrst_baddr", baddr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        chk("midrst_edge_fc2en", fc2en, 0);
        chk("midrst_edge_busy", busy, 0);
        exp_ra.delete(); exp_wa.delete(); exp_ba.delete();
        exp_idx.delete(); exp_dat.delete();
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        load(300, -7, 55);
        run_job(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/structure2_fc2_layer.md
STRUCTURE2_FC2_LAYER -- requirements
Module: structure2_fc2_layer

Interface
REQ-001 SHALL have parameter IN_LEN, default 128, meaning activations per neuron read from the fc1-to-fc2 buffer.
REQ-002 SHALL have parameter OUT_LEN, default 10, meaning fc2 neurons computed.
REQ-003 SHALL have parameter FRAC, default 8, meaning fractional bits of the signed fixed-point data.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit: single-cycle pulse meaning fc1 has finished writing the buffer.
REQ-007 SHALL have port fc2en, output, 1 bit: buffer read enable.
REQ-008 SHALL have port fc2dataaddr, output, 14 bits: buffer read address.
REQ-009 SHALL have port fc2dataout, input, 18 bits, signed: buffer read data, valid one cycle after fc2en.
REQ-010 SHALL have port waddr, output, 14 bits: weight ROM address; ROM data is valid one cycle later.
REQ-011 SHALL have port wdata, input, 18 bits, signed: weight.
REQ-012 SHALL have port baddr, output, 4 bits: bias ROM address.
REQ-013 SHALL have port bdata, input, 18 bits, signed: bias, valid one cycle after baddr.
REQ-014 SHALL have port out_valid, output, 1 bit: result strobe.
REQ-015 SHALL have port out_idx, output, 4 bits: neuron index of the result.
REQ-016 SHALL have port out_data, output, 18 bits, signed: neuron result.
REQ-017 SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until done.
REQ-018 SHALL have port done, output, 1 bit: single-cycle completion pulse.

Function
REQ-019 SHALL run the FSM IDLE -> READ -> DRAIN -> OUT; OUT SHALL go to READ if o<OUT_LEN-1, otherwise to FIN; FIN SHALL go to IDLE.
REQ-020 SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-021 SHALL, in READ for neuron o, hold fc2en=1 for IN_LEN consecutive cycles with fc2dataaddr=i and waddr=o*IN_LEN+i, for i=0..IN_LEN-1.
REQ-022 SHALL clear the accumulator on entry to READ and add fc2dataout*wdata (36-bit product) to a 40-bit signed accumulator one cycle after each read.
REQ-023 SHALL drive baddr=o during READ; DRAIN is one cycle and absorbs the last product.
REQ-024 SHALL, in OUT, compute (acc >>> FRAC) + bdata, saturate it to [-131072, 131071], and register it to out_data with out_valid=1 and out_idx=o for exactly one cycle.
REQ-025 SHALL take IN_LEN+2 cycles per neuron; done SHALL pulse in the cycle after the last out_valid, and busy SHALL fall with done.
REQ-026 SHALL hold fc2en=0 outside READ, and never write the buffer.

Reset
REQ-027 SHALL, on rst_n low at any time including mid-run, go to IDLE and drive fc2en, fc2dataaddr, waddr, baddr, out_valid, out_idx, out_data, busy and done to 0, with the accumulator and counters cleared.

Configuration
REQ-028 SHALL, with STRUCTURE2_FC2_RELU_EN defined, clamp negative saturated results to 0 before out_data; without it, SHALL output signed results unchanged.

Structure
REQ-029 SHALL take DATA_W=18, ADDR_W=14 and the FSM state encodings from shared package structure2_cnn_pkg.
REQ-030 SHALL place the multiply, accumulate, shift and saturation in sub-module structure2_fc2_mac; the FSM and address generation stay in the top.

Verification (IN_LEN=4, OUT_LEN=2, FRAC=8)
REQ-031 SHALL cover: activations all 256, weights all 256, bias 0 -> out_data 1024 for idx 0 and 1; done 13 cycles after the start pulse.
REQ-032 SHALL cover: weights all -256, bias 0 -> out_data -1024 without the macro, 0 with STRUCTURE2_FC2_RELU_EN.
REQ-033 SHALL cover: activations and weights 131071 -> out_data 131071; weights -131072 -> out_data -131072.
REQ-034 SHALL cover: the address trace -> fc2dataaddr 0,1,2,3,0,1,2,3; waddr 0..7; baddr 0 then 1.
REQ-035 SHALL cover: start re-pulsed while busy -> ignored; rst_n low mid-READ -> all outputs 0 next edge; a new start -> fc2dataaddr restarts at 0.
